bottom_linear_pipe: RTL and testbench
=====================================

BOTTOM_LINEAR_PIPE -- requirements
Module: bottom_linear_pipe

Interface
REQ-001 Parameter: LANES, default 4, number of independent S-box lanes processed per transfer (1..16).
REQ-002 Parameter: PIPE_STAGES, default 2, register stages between input and output (1 or 2).
REQ-003 Parameter: TAG_W, default 4, width of the sideband tag carried alongside each transfer (1..16).
REQ-004 Parameter: OUT_XOR, default 8'h00, constant XORed onto every lane's 8-bit output.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset_n  input  1  reset; synchronous, active-low.
REQ-007 in_valid  input  1  input transfer offered.
REQ-008 in_ready  output  1  block can accept the input transfer this cycle.
REQ-009 in_m  input  63*LANES  lane k occupies bits [63k+62:63k]; bit i is M[i] of lane k, M0..M62.
REQ-010 in_tag  input  TAG_W  sideband tag, returned unmodified with the result.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 out_w  output  8*LANES  lane k occupies bits [8k+7:8k]; bit 7 is W0, bit 0 is W7.
REQ-014 out_tag  output  TAG_W  tag of the transfer currently presented.

Function
REQ-015 Each lane shall compute the depth-16 bottom linear reverse transform over GF(2) (XOR only): intermediates P0..P28 and outputs W0..W7 exactly per the Boyar-Peralta depth-16 equations with M indices shifted to 0..62, followed by out_w lane XOR OUT_XOR.
REQ-016 A transfer shall occur on an input when in_valid=1 and in_ready=1 on the same rising edge, and on the output when out_valid=1 and out_ready=1.
REQ-017 With PIPE_STAGES=2, stage A shall register the 29-bit P vector per lane plus tag and a valid bit; stage B shall register W per lane plus tag and a valid bit.
REQ-018 With PIPE_STAGES=1, the only register stage shall hold W per lane plus tag and a valid bit.
REQ-019 Latency from input transfer to out_valid=1 shall be exactly PIPE_STAGES cycles when no stall occurs.
REQ-020 Throughput shall be one transfer per cycle while out_ready=1.
REQ-021 Each stage shall load when it is empty or its content leaves in the same cycle; otherwise it shall hold data, tag and valid unchanged.
REQ-022 in_ready shall equal NOT(stage-1 valid) OR (stage-1 advances this cycle); the combinational path from out_ready to in_ready is permitted.
REQ-023 When full with out_ready=0, the block shall hold PIPE_STAGES transfers, deassert in_ready, and keep out_w and out_tag stable until accepted.
REQ-024 Simultaneous input and output transfers on a full pipeline shall neither drop nor duplicate any transfer.
REQ-025 Results shall emerge in input order, each with its own tag; lanes shall never mix data across lane boundaries.
REQ-026 in_m and in_tag shall be ignored when in_valid=0; no X shall propagate to out_w while out_valid=1.

Reset
REQ-027 While reset_n=0 at a rising edge, all stage valid bits shall clear; out_valid=0 from the following cycle.
REQ-028 Reset mid-operation shall discard all in-flight transfers; none shall appear after reset.
REQ-029 Data and tag registers need not be reset; out_w and out_tag are don't-care while out_valid=0.
REQ-030 in_ready shall be 0 during reset and 1 in the first cycle after reset_n returns to 1.

Structure
REQ-031 A shared package shall hold the lane widths (M width 63, P width 29, W width 8) and the default OUT_XOR constant.
REQ-032 The per-lane XOR network shall be one sub-module, blr_lane, with separate P and W functions so the two-stage split can register the P vector; it shall be generated LANES times.
REQ-033 The handshake/valid logic shall be a single generic stage-control scheme shared by both PIPE_STAGES settings.

Verification
REQ-034 LANES=1, PIPE_STAGES=2, OUT_XOR=0, M all zero -> out_w=8'h00 after 2 cycles; only M[62]=1 -> 8'h49; only M[51]=1 -> 8'hFE.
REQ-035 LANES=4, lane0 only M[62]=1, lane2 only M[51]=1 -> out_w lanes {3,2,1,0} = {8'h00, 8'hFE, 8'h00, 8'h49}.
REQ-036 OUT_XOR=8'h63, M all zero -> every lane 8'h63; only M[62]=1 -> 8'h2A.
REQ-037 Back-to-back inputs with tags 1,2,3, out_ready=0 from cycle 2 to cycle 6 -> in_ready=0 once two transfers are held; tags 1,2,3 exit in order with matching data, none lost.
REQ-038 reset_n=0 for one cycle with two transfers in flight -> out_valid=0 next cycle, in_ready=1 after release, next input produces only its own result.
REQ-039 Random LANES=4 stream with random out_ready (both PIPE_STAGES values) checked against a reference GF(2) model -> zero mismatches, order and tags preserved.

Source files
------------

// File: rtl/bottom_linear_pipe_pkg.sv
// Shared widths and types for the bottom linear reverse-transform pipeline.
// Each lane maps 63 AND-layer products (M) to 8 output bits (W) via 29 XOR intermediates (P).
package bottom_linear_pipe_pkg;

    localparam int unsigned M_W = 63;
    localparam int unsigned P_W = 29;
    localparam int unsigned W_W = 8;

    localparam logic [W_W-1:0] OUT_XOR_DEFAULT = 8'h00;

    typedef logic [M_W-1:0] m_vec_t;
    typedef logic [P_W-1:0] p_vec_t;
    typedef logic [W_W-1:0] w_vec_t;

endpackage

// File: rtl/bottom_linear_pipe_blr_lane.sv
// One lane of the depth-16 bottom linear reverse transform, split into a P layer
// (from M) and a W layer (from P) so the pipeline can register P in between.
module blr_lane
    import bottom_linear_pipe_pkg::*;
(
    input  logic [M_W-1:0] m,
    output logic [P_W-1:0] p,
    input  logic [P_W-1:0] p_src,
    output logic [W_W-1:0] w
);

    // p[0..20] hold P0..P20, p[21..28] hold P22..P29 (the equations have no P21).
    function automatic p_vec_t blr_p(input m_vec_t mi);
        p_vec_t r;
        r[0]  = mi[51] ^ mi[60];
        r[1]  = mi[57] ^ mi[58];
        r[2]  = mi[53] ^ mi[61];
        r[3]  = mi[46] ^ mi[49];
        r[4]  = mi[47] ^ mi[55];
        r[5]  = mi[45] ^ mi[50];
        r[6]  = mi[48] ^ mi[59];
        r[7]  = r[0]   ^ r[1];
        r[8]  = mi[49] ^ mi[52];
        r[9]  = mi[54] ^ mi[62];
        r[10] = mi[56] ^ r[4];
        r[11] = r[0]   ^ r[3];
        r[12] = mi[45] ^ mi[47];
        r[13] = mi[48] ^ mi[50];
        r[14] = mi[48] ^ mi[61];
        r[15] = mi[53] ^ mi[58];
        r[16] = mi[56] ^ mi[60];
        r[17] = mi[57] ^ r[2];
        r[18] = mi[62] ^ r[5];
        r[19] = r[2]   ^ r[3];
        r[20] = r[4]   ^ r[6];
        r[21] = r[2]   ^ r[7];
        r[22] = r[7]   ^ r[8];
        r[23] = r[5]   ^ r[7];
        r[24] = r[6]   ^ r[10];
        r[25] = r[9]   ^ r[11];
        r[26] = r[10]  ^ r[18];
        r[27] = r[11]  ^ r[24];
        r[28] = r[15]  ^ r[20];
        return r;
    endfunction

    // Output bit 7 is W0, bit 0 is W7.
    function automatic w_vec_t blr_w(input p_vec_t pi);
        w_vec_t r;
        r[7] = pi[13] ^ pi[21];
        r[6] = pi[25] ^ pi[28];
        r[5] = pi[17] ^ pi[27];
        r[4] = pi[12] ^ pi[21];
        r[3] = pi[22] ^ pi[26];
        r[2] = pi[19] ^ pi[23];
        r[1] = pi[14] ^ pi[22];
        r[0] = pi[9]  ^ pi[16];
        return r;
    endfunction

    logic unused_m;
    logic unused_p;

    assign p = blr_p(m);
    assign w = blr_w(p_src);

    // Products M0..M44 feed other parts of the S-box, not this transform.
    assign unused_m = ^m[44:0];
    assign unused_p = ^{p_src[24], p_src[20], p_src[18], p_src[15], p_src[11:10], p_src[8:0]};

endmodule

// File: rtl/bottom_linear_pipe.sv
// Valid/ready pipeline of LANES bottom-linear lanes, 1 or 2 register stages,
// with a sideband tag travelling alongside each transfer.
module bottom_linear_pipe
    import bottom_linear_pipe_pkg::*;
#(
    parameter int unsigned    LANES       = 4,
    parameter int unsigned    PIPE_STAGES = 2,
    parameter int unsigned    TAG_W       = 4,
    parameter logic [W_W-1:0] OUT_XOR     = OUT_XOR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [M_W*LANES-1:0]   in_m,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W_W*LANES-1:0]   out_w,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int unsigned LAST = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] vld_d;
    logic [PIPE_STAGES-1:0] load;
    logic [PIPE_STAGES:0]   rdy;

    // Generic stage control: a stage loads when empty or when it drains this cycle,
    // so readiness ripples backwards from out_ready through every stage.
    always_comb begin
        rdy              = '0;
        rdy[PIPE_STAGES] = out_ready;
        for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            rdy[LAST-i] = !vld_q[LAST-i] || rdy[LAST-i+1];
        end
        load     = rdy[PIPE_STAGES-1:0];
        vld_d    = vld_q;
        vld_d[0] = load[0] ? in_valid : vld_q[0];
        for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
            vld_d[i] = load[i] ? vld_q[i-1] : vld_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign in_ready  = reset_n && load[0];
    assign out_valid = vld_q[LAST];

    logic [LANES-1:0][P_W-1:0] p_comb;
    logic [LANES-1:0][P_W-1:0] p_src;
    logic [LANES-1:0][W_W-1:0] w_comb;
    logic [LANES-1:0][W_W-1:0] w_xor;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        blr_lane u_lane (
            .m     (in_m[k*M_W +: M_W]),
            .p     (p_comb[k]),
            .p_src (p_src[k]),
            .w     (w_comb[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            w_xor[k] = w_comb[k] ^ OUT_XOR;
        end
    end

    logic             w_src_vld;
    logic [TAG_W-1:0] w_src_tag;

    if (PIPE_STAGES == 2) begin : g_two
        logic [LANES-1:0][P_W-1:0] p_q;
        logic [LANES-1:0][P_W-1:0] p_d;
        logic [TAG_W-1:0]          tag_p_q;
        logic [TAG_W-1:0]          tag_p_d;

        always_comb begin
            p_d     = p_q;
            tag_p_d = tag_p_q;
            if (load[0] && in_valid) begin
                p_d     = p_comb;
                tag_p_d = in_tag;
            end
        end

        always_ff @(posedge clk) begin
            p_q     <= p_d;
            tag_p_q <= tag_p_d;
        end

        assign p_src     = p_q;
        assign w_src_vld = vld_q[0];
        assign w_src_tag = tag_p_q;
    end else begin : g_one
        assign p_src     = p_comb;
        assign w_src_vld = in_valid;
        assign w_src_tag = in_tag;
    end

    logic [LANES-1:0][W_W-1:0] w_q;
    logic [LANES-1:0][W_W-1:0] w_d;
    logic [TAG_W-1:0]          tag_w_q;
    logic [TAG_W-1:0]          tag_w_d;

    // Data only captures real transfers, so a stalled output stays bit-stable.
    always_comb begin
        w_d     = w_q;
        tag_w_d = tag_w_q;
        if (load[LAST] && w_src_vld) begin
            w_d     = w_xor;
            tag_w_d = w_src_tag;
        end
    end

    always_ff @(posedge clk) begin
        w_q     <= w_d;
        tag_w_q <= tag_w_d;
    end

    assign out_w   = w_q;
    assign out_tag = tag_w_q;

endmodule

// File: tb/tb_bottom_linear_pipe.sv
// Directed and stall/reset tests for bottom_linear_pipe on a 2-stage/XOR=00 and a
// 1-stage/XOR=63 instance, with a flattened GF(2) reference scoreboard per instance.
module tb_bottom_linear_pipe;

    localparam int unsigned LANES = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned MW    = 63 * LANES;
    localparam int unsigned WW    = 8 * LANES;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             iv   [2];
    logic             ir   [2];
    logic             ov   [2];
    logic             ordy [2];
    logic [MW-1:0]    im   [2];
    logic [TAG_W-1:0] it   [2];
    logic [TAG_W-1:0] ot   [2];
    logic [WW-1:0]    ow   [2];

    int total = 0;
    int bad   = 0;

    bottom_linear_pipe #(
        .LANES       (LANES),
        .PIPE_STAGES (2),
        .TAG_W       (TAG_W),
        .OUT_XOR     (8'h00)
    ) u_dut0 (
        .clk       (clk),
        .reset_n   (rst_n),
        .in_valid  (iv[0]),
        .in_ready  (ir[0]),
        .in_m      (im[0]),
        .in_tag    (it[0]),
        .out_valid (ov[0]),
        .out_ready (ordy[0]),
        .out_w     (ow[0]),
        .out_tag   (ot[0])
    );

    bottom_linear_pipe #(
        .LANES       (LANES),
        .PIPE_STAGES (1),
        .TAG_W       (TAG_W),
        .OUT_XOR     (8'h63)
    ) u_dut1 (
        .clk       (clk),
        .reset_n   (rst_n),
        .in_valid  (iv[1]),
        .in_ready  (ir[1]),
        .in_m      (im[1]),
        .in_tag    (it[1]),
        .out_valid (ov[1]),
        .out_ready (ordy[1]),
        .out_w     (ow[1]),
        .out_tag   (ot[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each W bit written directly as the XOR of the M products it depends on.
    function automatic logic [7:0] w_ref(input logic [62:0] m);
        logic [7:0] w;
        w[7] = m[48]^m[50]^m[53]^m[61]^m[51]^m[60]^m[57]^m[58];
        w[6] = m[54]^m[62]^m[51]^m[60]^m[46]^m[49]^m[53]^m[58]^m[47]^m[55]^m[48]^m[59];
        w[5] = m[57]^m[53]^m[61]^m[51]^m[60]^m[46]^m[49]^m[48]^m[59]^m[56]^m[47]^m[55];
        w[4] = m[45]^m[47]^m[53]^m[61]^m[51]^m[60]^m[57]^m[58];
        w[3] = m[51]^m[60]^m[57]^m[58]^m[49]^m[52]^m[56]^m[47]^m[55]^m[62]^m[45]^m[50];
        w[2] = m[53]^m[61]^m[46]^m[49]^m[45]^m[50]^m[51]^m[60]^m[57]^m[58];
        w[1] = m[48]^m[61]^m[51]^m[60]^m[57]^m[58]^m[49]^m[52];
        w[0] = m[54]^m[62]^m[56]^m[60];
        return w;
    endfunction

    function automatic logic [WW-1:0] exp_w(input logic [MW-1:0] m, input logic [7:0] x);
        logic [WW-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            r[k*8 +: 8] = w_ref(m[k*63 +: 63]) ^ x;
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] rnd_m();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i*32 +: 32] = $urandom;
        end
        return t[MW-1:0];
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_mon
        localparam logic [7:0] XR = (d == 0) ? 8'h00 : 8'h63;
        logic [TAG_W+WW-1:0] q[$];
        int n_out = 0;

        always @(negedge clk) begin
            logic [TAG_W+WW-1:0] e;
            if (!rst_n) begin
                q.delete();
            end else begin
                if (ov[d] && ordy[d]) begin
                    n_out++;
                    if (q.size() == 0) begin
                        check("sb_spurious", 64'(ov[d]), 64'd0);
                    end else begin
                        e = q.pop_front();
                        check("sb_w", 64'(ow[d]), 64'(e[WW-1:0]));
                        check("sb_tag", 64'(ot[d]), 64'(e[TAG_W+WW-1:WW]));
                    end
                end
                if (iv[d] && ir[d]) begin
                    q.push_back({it[d], exp_w(im[d], XR)});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one transfer at posedge+1, check latency, then let it drain.
    task automatic directed(input int d, input logic [MW-1:0] m, input logic [TAG_W-1:0] tag,
                            input logic [WW-1:0] expw, input int lat, input string name);
        check({name, "_rdy"}, 64'(ir[d]), 64'd1);
        iv[d] = 1'b1;
        im[d] = m;
        it[d] = tag;
        step();
        iv[d] = 1'b0;
        im[d] = rnd_m();
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check({name, "_early"}, 64'(ov[d]), 64'd0);
            step();
        end
        @(negedge clk);
        check({name, "_vld"}, 64'(ov[d]), 64'd1);
        check({name, "_w"}, 64'(ow[d]), 64'(expw));
        check({name, "_tag"}, 64'(ot[d]), 64'(tag));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [MW-1:0] v;
        logic [MW-1:0] a;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d]   = 1'b0;
            im[d]   = '0;
            it[d]   = '0;
            ordy[d] = 1'b1;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ov0", 64'(ov[0]), 64'd0);
        check("rst_ov1", 64'(ov[1]), 64'd0);
        check("rst_ir0", 64'(ir[0]), 64'd0);
        check("rst_ir1", 64'(ir[1]), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_ir0", 64'(ir[0]), 64'd1);
        check("rel_ir1", 64'(ir[1]), 64'd1);
        step();

        directed(0, '0, 4'd1, 32'h0000_0000, 2, "zero");
        v = '0; v[62] = 1'b1;
        directed(0, v, 4'd2, 32'h0000_0049, 2, "m62");
        v = '0; v[51] = 1'b1;
        directed(0, v, 4'd3, 32'h0000_00FE, 2, "m51");
        v = '0; v[62] = 1'b1; v[126+51] = 1'b1;
        directed(0, v, 4'd4, 32'h00FE_0049, 2, "lanes");
        v = '0; v[189+62] = 1'b1;
        directed(0, v, 4'd5, 32'h4900_0000, 2, "lane3");
        @(negedge clk);
        check("idle_ov0", 64'(ov[0]), 64'd0);
        step();
        directed(1, '0, 4'd6, 32'h6363_6363, 1, "xor_zero");
        v = '0; v[62] = 1'b1;
        directed(1, v, 4'd7, 32'h6363_632A, 1, "xor_m62");

        // Back-pressure: tags 1,2,3 offered back to back, consumer stalls.
        a = rnd_m();
        iv[0] = 1'b1; im[0] = a; it[0] = 4'd1;
        @(negedge clk);
        check("bp_rdy0", 64'(ir[0]), 64'd1);
        step();
        im[0] = rnd_m(); it[0] = 4'd2; ordy[0] = 1'b0;
        @(negedge clk);
        check("bp_rdy1", 64'(ir[0]), 64'd1);
        step();
        im[0] = rnd_m(); it[0] = 4'd3;
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            check("bp_full_ir", 64'(ir[0]), 64'd0);
            check("bp_hold_vld", 64'(ov[0]), 64'd1);
            check("bp_hold_tag", 64'(ot[0]), 64'd1);
            check("bp_hold_w", 64'(ow[0]), 64'(exp_w(a, 8'h00)));
            step();
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        check("bp_release_ir", 64'(ir[0]), 64'd1);
        step();
        iv[0] = 1'b0;
        @(negedge clk);
        check("bp_tag2", 64'(ot[0]), 64'd2);
        step();
        @(negedge clk);
        check("bp_tag3", 64'(ot[0]), 64'd3);
        step();
        @(negedge clk);
        check("bp_empty", 64'(ov[0]), 64'd0);
        step();

        // Reset with two transfers held in the pipeline.
        ordy[0] = 1'b0;
        iv[0] = 1'b1; im[0] = rnd_m(); it[0] = 4'd10;
        step();
        im[0] = rnd_m(); it[0] = 4'd11;
        step();
        iv[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ir", 64'(ir[0]), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ov", 64'(ov[0]), 64'd0);
        check("mid_rst_rel_ir", 64'(ir[0]), 64'd1);
        ordy[0] = 1'b1;
        step();
        v = '0; v[51] = 1'b1;
        directed(0, v, 4'd12, 32'h0000_00FE, 2, "post_rst");
        repeat (3) begin
            @(negedge clk);
            check("post_rst_stale", 64'(ov[0]), 64'd0);
        end
        step();

        // Random stream on both instances with random consumer stalls.
        for (int n = 0; n < 300; n++) begin
            for (int d = 0; d < 2; d++) begin
                iv[d]   = ($urandom % 4) != 0;
                im[d]   = rnd_m();
                it[d]   = TAG_W'($urandom);
                ordy[d] = ($urandom % 3) != 0;
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
        end
        repeat (6) step();
        check("drain0", 64'(g_mon[0].q.size()), 64'd0);
        check("drain1", 64'(g_mon[1].q.size()), 64'd0);
        check("traffic0", 64'(g_mon[0].n_out > 100), 64'd1);
        check("traffic1", 64'(g_mon[1].n_out > 100), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
